// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the common data bus: the existing tag/packet structs,
// the per-FU request packet and the default FU count.
package cdb_arbiter_pkg;

  localparam int ROB_LEN    = 32;
  localparam int XLEN       = 32;
  localparam int TAG_W      = $clog2(ROB_LEN);
  localparam int DATA_W     = XLEN;
  localparam int NUM_FU_DEF = 4;

  // Tag as seen by the map table and reservation stations.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             valid;
  } PHYS_REG_TAG;

  // One broadcast on the common data bus.
  typedef struct packed {
    PHYS_REG_TAG       reg_tag;
    logic [DATA_W-1:0] reg_value;
  } CDB_PACKET;

  // One completed result offered by a functional unit.
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic              valid;
    logic [DATA_W-1:0] value;
  } FU2CDB_PACKET;

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU-to-CDB request bus plus the broadcast packet.
//
// Handshake: FU i holds fu_valid[i] with stable fu_tag[i]/fu_value[i] until
// it sees fu_ready[i]; a transfer happens in any cycle where both are 1, and
// the FU must drop or replace its request after that edge. fu_ready never
// depends on the FU seeing ready first, and at most one ready bit is set.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = NUM_FU_DEF
);
  logic [NUM_FU-1:0]             fu_valid;
  logic [NUM_FU-1:0][TAG_W-1:0]  fu_tag;
  logic [NUM_FU-1:0][DATA_W-1:0] fu_value;
  logic [NUM_FU-1:0]             fu_ready;
  logic                          squash;
  CDB_PACKET                     cdb_packet_out;

  // Functional units / recovery logic side.
  modport master (
    output fu_valid, fu_tag, fu_value, squash,
    input  fu_ready, cdb_packet_out
  );

  // Arbiter side.
  modport slave (
    input  fu_valid, fu_tag, fu_value, squash,
    output fu_ready, cdb_packet_out
  );
endinterface

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational round-robin pick: first set request at or after base,
// wrapping modulo N. Returns one-hot grant, its index and any_grant.
module cdb_arbiter_rr_picker #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] base,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] winner,
  output logic          any_grant
);

  // Scan from base; the first hit locks out every later index.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant     = '0;
    winner    = '0;
    any_grant = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(base) + k) % N;
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        winner     = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: grants one FU per cycle, broadcasts its result
// one cycle later as a registered packet, and suppresses grants on squash.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = NUM_FU_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  cdb_arbiter_if.slave              bus,
  output logic [$clog2(NUM_FU)-1:0] dbg_ptr
);

  localparam int PW = $clog2(NUM_FU);

  logic [NUM_FU-1:0] grant;
  logic [PW-1:0]     winner;
  logic [PW-1:0]     ptr_q;
  logic              any_grant;
  logic              grant_en;
  logic              xfer;
  CDB_PACKET         pkt_q;

  cdb_arbiter_rr_picker #(.N(NUM_FU), .PW(PW)) u_picker (
    .req       (bus.fu_valid),
    .base      (ptr_q),
    .grant     (grant),
    .winner    (winner),
    .any_grant (any_grant)
  );

  // Grants are withheld while reset is held or a squash is in progress, so
  // no FU believes it transferred a result that will never be broadcast.
  assign grant_en     = reset & ~bus.squash;
  assign xfer         = any_grant & grant_en;
  assign bus.fu_ready = grant & {NUM_FU{grant_en}};

  // Pointer advance and broadcast register; tag/value hold when idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
      pkt_q <= '0;
    end else if (xfer) begin
      ptr_q                 <= (winner == PW'(NUM_FU - 1)) ? '0 : winner + 1'b1;
      pkt_q.reg_tag.tag     <= bus.fu_tag[winner];
      pkt_q.reg_tag.valid   <= 1'b1;
      pkt_q.reg_value       <= bus.fu_value[winner];
    end else begin
      pkt_q.reg_tag.valid   <= 1'b0;
    end
  end

  assign bus.cdb_packet_out = pkt_q;
  assign dbg_ptr            = ptr_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed sequences plus a random phase. Granted
// results are queued when the handshake completes and compared against the
// broadcast packet one cycle later.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NFU = 4;
  localparam int W   = TAG_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset;
  logic [1:0] dbg_ptr;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  cdb_arbiter_if #(.NUM_FU(NFU)) bus ();

  cdb_arbiter #(.NUM_FU(NFU)) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .dbg_ptr (dbg_ptr)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           vectors;
  int           miscompares;

  FU2CDB_PACKET fu[NFU];
  FU2CDB_PACKET held[NFU];
  logic         held_v[NFU];
  logic         sq;
  int           mptr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference round-robin pick over the FU model's valid bits.
  function automatic logic [NFU-1:0] rr_expect(input logic [NFU-1:0] v, input int p);
    for (int k = 0; k < NFU; k++) begin
      if (v[(p + k) % NFU]) return NFU'(1) << ((p + k) % NFU);
    end
    return '0;
  endfunction

  function automatic logic [NFU-1:0] fu_valid_vec();
    logic [NFU-1:0] v;
    for (int i = 0; i < NFU; i++) v[i] = fu[i].valid;
    return v;
  endfunction

  // ---------------- driver ----------------
  // Drive one cycle from the FU model, check the grant mid-cycle, and queue
  // the expected broadcast for any completed handshake.
  task automatic apply(input logic [NFU-1:0] exp_ready);
    logic [NFU-1:0] hs;
    for (int i = 0; i < NFU; i++) begin
      if (held_v[i])
        assert (fu[i] == held[i]) else $error("FU %0d request changed before grant", i);
      bus.fu_valid[i] = fu[i].valid;
      bus.fu_tag[i]   = fu[i].tag;
      bus.fu_value[i] = fu[i].value;
    end
    bus.squash = sq;
    @(negedge clock);
    check("fu_ready", 64'(bus.fu_ready), 64'(exp_ready));
    hs = bus.fu_ready & bus.fu_valid;
    for (int i = 0; i < NFU; i++) begin
      held_v[i] = fu[i].valid & ~hs[i] & ~sq;
      held[i]   = fu[i];
    end
    @(posedge clock);
    for (int i = 0; i < NFU; i++) begin
      if (hs[i]) begin
        if (!sq) exp_q.push_back({fu[i].tag, fu[i].value});
        fu[i].valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic load(input int i, input int tag, input int value);
    fu[i].valid = 1'b1;
    fu[i].tag   = TAG_W'(tag);
    fu[i].value = DATA_W'(value);
  endtask

  // ---------------- monitor ----------------
  // Every out-of-reset cycle: valid must match whether a broadcast is owed,
  // and an owed broadcast must carry the queued tag/value.
  always @(negedge clock) begin
    if (reset) begin
      check("cdb_valid", 64'(bus.cdb_packet_out.reg_tag.valid), 64'(exp_q.size() != 0));
      if (bus.cdb_packet_out.reg_tag.valid && exp_q.size() != 0)
        check("cdb_packet",
              64'({bus.cdb_packet_out.reg_tag.tag, bus.cdb_packet_out.reg_value}),
              64'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    vectors = 0;
    miscompares = 0;
    sq = 1'b0;
    mptr = 0;
    for (int i = 0; i < NFU; i++) begin
      fu[i] = '0;
      held[i] = '0;
      held_v[i] = 1'b0;
    end
    reset = 1'b0;
    bus.fu_valid = '0;
    bus.fu_tag = '0;
    bus.fu_value = '0;
    bus.squash = 1'b0;

    // Reset held: outputs cleared, no grant even with requests present.
    #3;
    check("rst_valid", 64'(bus.cdb_packet_out.reg_tag.valid), 64'(0));
    check("rst_tag", 64'(bus.cdb_packet_out.reg_tag.tag), 64'(0));
    check("rst_value", 64'(bus.cdb_packet_out.reg_value), 64'(0));
    check("rst_ptr", 64'(dbg_ptr), 64'(0));
    bus.fu_valid = 4'b1111;
    #1;
    check("rst_ready", 64'(bus.fu_ready), 64'(0));
    bus.fu_valid = '0;
    #18 reset = 1'b1;

    // 1: idle bus.
    for (int c = 0; c < 3; c++) begin
      apply(4'b0000);
      check("idle_tag", 64'(bus.cdb_packet_out.reg_tag.tag), 64'(0));
      check("idle_value", 64'(bus.cdb_packet_out.reg_value), 64'(0));
    end

    // 2: all four valid, served in order, pointer wraps to 0.
    for (int i = 0; i < NFU; i++) load(i, i + 1, (i + 1) * 10);
    apply(4'b0001);
    apply(4'b0010);
    apply(4'b0100);
    apply(4'b1000);
    check("wrap_ptr", 64'(dbg_ptr), 64'(0));
    apply(4'b0000);

    // 3: ptr=2 after FU1; FU0 and FU3 pending -> FU3 then FU0.
    load(1, 11, 110);
    apply(4'b0010);
    check("ptr_after_fu1", 64'(dbg_ptr), 64'(2));
    load(0, 13, 130);
    load(3, 14, 140);
    apply(4'b1000);
    apply(4'b0001);
    check("ptr_after_fu0", 64'(dbg_ptr), 64'(1));

    // 4: single requester, back-to-back tags 5, 6, 7.
    load(2, 5, 50);
    apply(4'b0100);
    load(2, 6, 60);
    apply(4'b0100);
    load(2, 7, 70);
    apply(4'b0100);
    check("ptr_after_b2b", 64'(dbg_ptr), 64'(3));

    // 5: squash while FU1 waits; packet from the prior grant is still shown.
    load(1, 9, 90);
    sq = 1'b1;
    apply(4'b0000);
    check("squash_valid", 64'(bus.cdb_packet_out.reg_tag.valid), 64'(0));
    check("squash_ptr", 64'(dbg_ptr), 64'(3));
    apply(4'b0000);
    sq = 1'b0;
    apply(4'b0010);
    check("post_squash_ptr", 64'(dbg_ptr), 64'(2));

    // 6: async reset while a broadcast (tag 3) is on the bus.
    load(1, 3, 33);
    apply(4'b0010);
    check("pre_rst_valid", 64'(bus.cdb_packet_out.reg_tag.valid), 64'(1));
    check("pre_rst_pkt",
          64'({bus.cdb_packet_out.reg_tag.tag, bus.cdb_packet_out.reg_value}),
          64'(exp_q.pop_front()));
    #1 reset = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.cdb_packet_out.reg_tag.valid), 64'(0));
    check("mid_rst_ptr", 64'(dbg_ptr), 64'(0));
    bus.fu_valid = 4'b1000;
    #1;
    check("mid_rst_ready", 64'(bus.fu_ready), 64'(0));
    bus.fu_valid = '0;
    for (int i = 0; i < NFU; i++) held_v[i] = 1'b0;
    @(negedge clock);
    #2 reset = 1'b1;
    @(posedge clock);
    #1;
    load(3, 12, 120);
    apply(4'b1000);
    check("post_rst_wrap_ptr", 64'(dbg_ptr), 64'(0));

    // Random phase against the reference pick.
    mptr = 0;
    for (int c = 0; c < 40; c++) begin
      logic [NFU-1:0] e;
      for (int i = 0; i < NFU; i++)
        if (!fu[i].valid && $urandom_range(0, 99) < 50)
          load(i, int'($urandom_range(0, ROB_LEN - 1)), int'($urandom));
      e = rr_expect(fu_valid_vec(), mptr);
      apply(e);
      for (int i = 0; i < NFU; i++)
        if (e[i]) mptr = (i + 1) % NFU;
    end
    for (int i = 0; i < NFU; i++) fu[i].valid = 1'b0;
    for (int i = 0; i < NFU; i++) held_v[i] = 1'b0;
    apply(4'b0000);
    apply(4'b0000);
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
